// File: rtl/mealy_fsm_pkg.sv
// Shared description of the four-state Mealy encoder: state encodings,
// next-state/output tables and the inverse (y -> x) relation used by the decoder.
package mealy_fsm_pkg;

    typedef enum logic [1:0] {
        S_A = 2'b00,
        S_B = 2'b01,
        S_C = 2'b10,
        S_D = 2'b11
    } state_t;

    function automatic state_t next_state(input state_t s, input logic x);
        state_t n;
        case (s)
            S_A:     n = x ? S_C : S_B;
            S_B:     n = x ? S_D : S_C;
            S_C:     n = x ? S_D : S_B;
            default: n = x ? S_A : S_C;
        endcase
        return n;
    endfunction

    function automatic logic enc_output(input state_t s, input logic x);
        logic y;
        case (s)
            S_A:     y = ~x;
            S_B:     y = x;
            S_C:     y = x;
            default: y = ~x;
        endcase
        return y;
    endfunction

    // The encoder inverts x only in S_a and S_d, so the inverse is a single XOR.
    function automatic logic decode_x(input state_t s, input logic y);
        return y ^ ((s == S_A) || (s == S_D));
    endfunction

endpackage

// File: rtl/mealy_inverse_decoder_if.sv
// Symbol stream in, recovered bits/bytes and tracker status out.
interface mealy_inverse_decoder_if;
    logic       y_valid;
    logic       y_in;
    logic       resync;
    logic       x_out;
    logic       x_valid;
    logic [1:0] state;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic [2:0] bit_count;

    modport master (
        output y_valid, y_in, resync,
        input  x_out, x_valid, state, byte_out, byte_valid, bit_count
    );

    modport slave (
        input  y_valid, y_in, resync,
        output x_out, x_valid, state, byte_out, byte_valid, bit_count
    );
endinterface

// File: rtl/mealy_inverse_decoder_bit_packer.sv
// Collects recovered bits LSB first and emits a byte with a one-cycle strobe
// when the eighth bit arrives.
module bit_packer (
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_in,
    input  logic       valid,
    input  logic       clear,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic [2:0] count
);

    logic [6:0] partial;

    // clear drops the partial byte but byte_out keeps the last completed byte.
    always_ff @(posedge clk) begin
        if (!reset) begin
            partial    <= '0;
            count      <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (clear) begin
                partial <= '0;
                count   <= '0;
            end else if (valid) begin
                if (count == 3'd7) begin
                    byte_out   <= {bit_in, partial};
                    byte_valid <= 1'b1;
                    partial    <= '0;
                    count      <= '0;
                end else begin
                    partial[count] <= bit_in;
                    count          <= count + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/mealy_inverse_decoder.sv
// Tracks the Mealy encoder state from its observed outputs, recovers the
// encoder input bit per accepted symbol and packs the bits into bytes.
module mealy_inverse_decoder
    import mealy_fsm_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    mealy_inverse_decoder_if.slave  bus
);

    state_t state_q, state_d;
    logic   x_out_q, x_out_d;
    logic   x_valid_q, x_valid_d;
    logic   x_rec;
    logic   accept;

    assign accept = bus.y_valid && !bus.resync;
    assign x_rec  = decode_x(state_q, bus.y_in);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_A;
            x_out_q   <= 1'b0;
            x_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_out_q   <= x_out_d;
            x_valid_q <= x_valid_d;
        end
    end

    // resync wins over a same-cycle symbol, which is simply dropped.
    always_comb begin
        state_d   = state_q;
        x_out_d   = x_out_q;
        x_valid_d = 1'b0;
        if (bus.resync) begin
            state_d = S_A;
        end else if (bus.y_valid) begin
            state_d   = next_state(state_q, x_rec);
            x_out_d   = x_rec;
            x_valid_d = 1'b1;
        end
    end

    bit_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .bit_in     (x_rec),
        .valid      (accept),
        .clear      (bus.resync),
        .byte_out   (bus.byte_out),
        .byte_valid (bus.byte_valid),
        .count      (bus.bit_count)
    );

    assign bus.x_out   = x_out_q;
    assign bus.x_valid = x_valid_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_mealy_inverse_decoder.sv
// Scoreboard bench: stimulus pushes expected results from a table-driven
// encoder model, a negedge monitor pops and compares on every x_valid.
module tb_mealy_inverse_decoder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   bv_pulses = 0;

    mealy_inverse_decoder_if bus();

    mealy_inverse_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Encoder tables indexed by state*2+x (a=0,b=1,c=2,d=3).
    int NXT[8] = '{1, 2, 2, 3, 1, 3, 2, 0};
    int YOUT[8] = '{1, 0, 0, 1, 0, 1, 1, 0};

    typedef struct {
        logic       x;
        logic [1:0] st;
        logic [2:0] cnt;
        logic       bv;
        logic [7:0] by;
        int         due;
    } exp_t;

    exp_t sb[$];

    int         m_state = 0;
    int         m_cnt = 0;
    logic [7:0] m_acc = '0;
    logic [7:0] m_byte = '0;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Drives one cycle of inputs at the negedge and advances the reference model.
    task automatic applyStimulus(input logic rst_n, input logic rs, input logic yv,
                                 input logic yin, input int x_force);
        exp_t e;
        int   x;
        @(negedge clk);
        reset       = rst_n;
        bus.resync  = rs;
        bus.y_valid = yv;
        bus.y_in    = yin;
        if (!rst_n) begin
            m_state = 0; m_cnt = 0; m_acc = '0; m_byte = '0;
        end else if (rs) begin
            m_state = 0; m_cnt = 0; m_acc = '0;
        end else if (yv) begin
            x = (x_force >= 0) ? x_force : ((YOUT[m_state*2+1] == int'(yin)) ? 1 : 0);
            m_acc[m_cnt] = x[0];
            e.bv = 1'b0;
            if (m_cnt == 7) begin
                m_byte = m_acc; e.bv = 1'b1; m_cnt = 0; m_acc = '0;
            end else begin
                m_cnt++;
            end
            m_state = NXT[m_state*2+x];
            e.x = x[0]; e.st = 2'(m_state); e.cnt = 3'(m_cnt); e.by = m_byte;
            e.due = cycle + 1;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, -1);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, -1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle(1);
    endtask

    task automatic sendY(input logic [7:0] ys, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b1, ys[i], -1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.byte_valid) bv_pulses++;
        if (bus.byte_valid && !bus.x_valid)
            checkOutput("byte_valid_without_x_valid", 8'(bus.x_valid), 8'h01);
        if (bus.x_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_x_valid", 8'(bus.x_valid), 8'h00);
            end else begin
                e = sb.pop_front();
                checkOutput("x_valid_latency", 8'(cycle - e.due), 8'h00);
                checkOutput("x_out", 8'(bus.x_out), 8'(e.x));
                checkOutput("state", 8'(bus.state), 8'(e.st));
                checkOutput("bit_count", 8'(bus.bit_count), 8'(e.cnt));
                checkOutput("byte_valid", 8'(bus.byte_valid), 8'(e.bv));
                checkOutput("byte_out", bus.byte_out, e.by);
            end
        end else if (sb.size() != 0 && sb[0].due <= cycle) begin
            e = sb.pop_front();
            checkOutput("missing_x_valid", 8'(bus.x_valid), 8'h01);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, got cycle %0d expected < 20000", cycle);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int p0;
        int enc_s;
        int xr;
        logic yv;
        bus.y_valid = 1'b0;
        bus.y_in    = 1'b0;
        bus.resync  = 1'b0;

        doReset();
        checkOutput("reset_state", 8'(bus.state), 8'h00);
        checkOutput("reset_x_out", 8'(bus.x_out), 8'h00);
        checkOutput("reset_x_valid", 8'(bus.x_valid), 8'h00);
        checkOutput("reset_byte_out", bus.byte_out, 8'h00);
        checkOutput("reset_byte_valid", 8'(bus.byte_valid), 8'h00);
        checkOutput("reset_bit_count", 8'(bus.bit_count), 8'h00);

        $display("[TB] directed y=0,1,0,0");
        sendY(8'b0000_0010, 4);
        idle(2);
        checkOutput("seq_0100_state", 8'(bus.state), 8'h02);
        checkOutput("seq_0100_x_out", 8'(bus.x_out), 8'h01);

        $display("[TB] directed y=1,0,0,0");
        doReset();
        sendY(8'b0000_0001, 4);
        idle(2);
        checkOutput("seq_1000_state", 8'(bus.state), 8'h02);
        checkOutput("seq_1000_x_out", 8'(bus.x_out), 8'h00);

        $display("[TB] directed byte 0x55");
        doReset();
        p0 = bv_pulses;
        sendY(8'b1111_1100, 8);
        idle(2);
        checkOutput("byte55_byte_out", bus.byte_out, 8'h55);
        checkOutput("byte55_state", 8'(bus.state), 8'h02);
        checkOutput("byte55_bit_count", 8'(bus.bit_count), 8'h00);
        checkOutput("byte55_pulses", 8'(bv_pulses - p0), 8'h01);

        $display("[TB] resync with same-cycle symbol");
        sendY(8'(3'($urandom_range(0, 7))), 3);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'($urandom_range(0, 1)), -1);
        idle(1);
        checkOutput("resync_x_valid", 8'(bus.x_valid), 8'h00);
        checkOutput("resync_byte_valid", 8'(bus.byte_valid), 8'h00);
        checkOutput("resync_state", 8'(bus.state), 8'h00);
        checkOutput("resync_bit_count", 8'(bus.bit_count), 8'h00);
        checkOutput("resync_byte_out", bus.byte_out, 8'h55);

        $display("[TB] mid-byte reset");
        sendY(8'($urandom_range(0, 255)), 5);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), -1);
        idle(1);
        checkOutput("midrst_state", 8'(bus.state), 8'h00);
        checkOutput("midrst_x_out", 8'(bus.x_out), 8'h00);
        checkOutput("midrst_x_valid", 8'(bus.x_valid), 8'h00);
        checkOutput("midrst_byte_out", bus.byte_out, 8'h00);
        checkOutput("midrst_byte_valid", 8'(bus.byte_valid), 8'h00);
        checkOutput("midrst_bit_count", 8'(bus.bit_count), 8'h00);
        p0 = bv_pulses;
        sendY(8'($urandom_range(0, 255)), 8);
        idle(2);
        checkOutput("midrst_fresh_byte", bus.byte_out, m_byte);
        checkOutput("midrst_fresh_pulses", 8'(bv_pulses - p0), 8'h01);

        $display("[TB] random encoder stream with gaps");
        doReset();
        enc_s = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                applyStimulus(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
                enc_s = 0;
            end else begin
                yv = ($urandom_range(0, 99) < 70);
                if (yv) begin
                    xr = int'($urandom_range(0, 1));
                    applyStimulus(1'b1, 1'b0, 1'b1, YOUT[enc_s*2+xr][0], xr);
                    enc_s = NXT[enc_s*2+xr];
                end else begin
                    applyStimulus(1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)), -1);
                end
            end
        end
        idle(3);
        checkOutput("random_final_state", 8'(bus.state), 8'(enc_s));
        checkOutput("random_final_byte", bus.byte_out, m_byte);
        checkOutput("scoreboard_drained", 8'(sb.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mealy_inverse_decoder.md
MEALY_INVERSE_DECODER -- requirements
Module: mealy_inverse_decoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-low reset sampled on the rising edge of clk.
REQ-003 SHALL have port y_valid, input, 1 bit: when 1, y_in carries one observed encoder output symbol this cycle.
REQ-004 SHALL have port y_in, input, 1 bit: observed Mealy encoder output y.
REQ-005 SHALL have port resync, input, 1 bit: forces the tracker back to S_a and clears the byte packer.
REQ-006 SHALL have port x_out, output, 1 bit: recovered encoder input x.
REQ-007 SHALL have port x_valid, output, 1 bit: one-cycle strobe qualifying x_out.
REQ-008 SHALL have port state, output, 2 bits: tracked encoder state after the last accepted symbol.
REQ-009 SHALL have port byte_out, output, 8 bits: packed recovered bits, LSB first.
REQ-010 SHALL have port byte_valid, output, 1 bit: one-cycle strobe qualifying byte_out.
REQ-011 SHALL have port bit_count, output, 3 bits: number of bits currently held in the packer.

Function
REQ-012 SHALL track the encoder machine: S_a=00, S_b=01, S_c=10, S_d=11; transitions (state,x->next,y): a,1->c,0; a,0->b,1; b,1->d,1; b,0->c,0; c,1->d,1; c,0->b,0; d,1->a,0; d,0->c,1.
REQ-013 SHALL recover the bit on an accepted symbol as x = y_in XOR (state==S_a OR state==S_d).
REQ-014 SHALL, on an accepted symbol (y_valid=1, resync=0), update state to next(state,x) at the same edge.
REQ-015 SHALL register x_out and assert x_valid exactly one cycle after y_valid is sampled high; x_valid SHALL be 0 otherwise.
REQ-016 SHALL hold state, x_out, byte_out unchanged when y_valid=0.
REQ-017 SHALL shift each recovered bit into position bit_count of the packer and increment bit_count modulo 8.
REQ-018 SHALL, on the 8th accepted bit, present the complete byte on byte_out, pulse byte_valid on the same cycle as that bit's x_valid, and wrap bit_count to 0.
REQ-019 SHALL accept one symbol per cycle back-to-back with no bubbles; consecutive bytes SHALL be emitted with no lost bits.
REQ-020 SHALL, when resync=1, set state to S_a, clear bit_count and the partial byte, and discard any same-cycle y_valid symbol (no x_valid, no byte_valid the next cycle).
REQ-021 SHALL leave byte_out holding the last completed byte after resync.

Reset
REQ-022 SHALL, when reset=0 at a rising edge, set state=S_a, x_out=0, x_valid=0, byte_out=0x00, byte_valid=0, bit_count=0.
REQ-023 SHALL give reset priority over resync and y_valid; a mid-byte reset SHALL discard the partial byte.
REQ-024 SHALL accept symbols from the first edge at which reset is sampled as 1.

Structure
REQ-025 SHALL take the state encodings S_a..S_d and the next-state/output tables from a shared package mealy_fsm_pkg, also used by the encoder.
REQ-026 SHALL implement the 8-bit LSB-first packer as sub-module bit_packer (inputs bit, valid, clear; outputs byte, byte_valid, count).

Verification
REQ-027 SHALL test: after reset, y_in=0,1,0,0 with y_valid=1 -> x_out=1,1,1,1; state=10,11,00,10.
REQ-028 SHALL test: from reset, y_in=1,0,0,0 -> x_out=0,0,0,0; final state=10.
REQ-029 SHALL test: from reset, y_in=0,0,1,1,1,1,1,1 back-to-back -> byte_valid pulses once, byte_out=0x55, state=10, bit_count=0.
REQ-030 SHALL test: 3 symbols then resync=1 with y_valid=1 -> no x_valid next cycle, state=00, bit_count=0, byte_out unchanged.
REQ-031 SHALL test: reset=0 asserted after 5 bits -> all outputs return to reset values; the next 8 symbols produce a fresh byte.
REQ-032 SHALL test: random x driven through a reference encoder model with random y_valid gaps -> recovered x and bytes match bit-for-bit.
